// File: rtl/jk_mod_counter.sv
// Modulo-MODULUS up/down counter held as JK storage bits, exporting per-bit J/K excitation.
// Optional macro JK_CNT_SATURATE_EN: saturate at the ends instead of wrapping.
module jk_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic             tc,
  output logic             wrap,
  output logic             err
);

  localparam logic [WIDTH:0] MOD  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST = MOD - 1'b1;

  generate
    if (WIDTH < 2 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_cfg
      $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d, nxt;
  logic [WIDTH:0]   q_ext, din_ext;
  logic             wrap_q, wrap_d, err_q, err_d;
  logic             at_top, at_bot;

  always_comb begin
    q_ext   = {1'b0, q_q};
    din_ext = {1'b0, din};
    at_top  = (q_ext == LAST);
    at_bot  = (q_q == '0);
    nxt     = q_q;
    err_d   = err_q;
    wrap_d  = 1'b0;
    if (load) begin
      // A rejected load still blocks the count step for this cycle.
      if (din_ext < MOD) nxt = din;
      else               err_d = 1'b1;
    end else if (en) begin
      if (up) begin
        if (at_top) begin
`ifdef JK_CNT_SATURATE_EN
          nxt = q_q;
`else
          nxt    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          nxt = WIDTH'(q_ext + 1'b1);
        end
      end else begin
        if (at_bot) begin
`ifdef JK_CNT_SATURATE_EN
          nxt = q_q;
`else
          nxt    = WIDTH'(LAST);
          wrap_d = 1'b1;
`endif
        end else begin
          nxt = WIDTH'(q_ext - 1'b1);
        end
      end
    end
    // Set/clear-only excitation: J=K=1 never occurs.
    j_o = ~q_q & nxt;
    k_o = q_q & ~nxt;
    q_d = (j_o & ~q_q) | (~k_o & q_q);
    tc  = en & ~load & ((up & at_top) | (~up & at_bot));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: driver pushes model expectations, monitor pops and compares.
module tb_jk_mod_counter;
  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst, en, up, load;
  logic [W-1:0] din;
  logic [W-1:0] q, j_o, k_o;
  logic         tc, wrap, err;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
    .q(q), .j_o(j_o), .k_o(k_o), .tc(tc), .wrap(wrap), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q, j, k, tc, wrap, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state as plain integers.
  int m_q = 0, m_wrap = 0, m_err = 0;

  task automatic cmp(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle: apply inputs at negedge, push what the DUT must show now, advance model at posedge.
  task automatic step(input int r, input int e, input int u, input int l, input int d);
    int nxt, tcv, wrapped, e_err;
    exp_t x;
    @(negedge clk);
    rst = r[0]; en = e[0]; up = u[0]; load = l[0]; din = d[W-1:0];
    if (r == 0) begin m_q = 0; m_wrap = 0; m_err = 0; end
    nxt = m_q; e_err = m_err; wrapped = 0;
    if (l != 0) begin
      if (d < M) nxt = d; else e_err = 1;
    end else if (e != 0) begin
      if (u != 0) begin
        if (m_q == M - 1) begin
`ifdef JK_CNT_SATURATE_EN
          nxt = m_q;
`else
          nxt = 0; wrapped = 1;
`endif
        end else nxt = m_q + 1;
      end else begin
        if (m_q == 0) begin
`ifdef JK_CNT_SATURATE_EN
          nxt = m_q;
`else
          nxt = M - 1; wrapped = 1;
`endif
        end else nxt = m_q - 1;
      end
    end
    tcv = (e != 0 && l == 0 && ((u != 0 && m_q == M - 1) || (u == 0 && m_q == 0))) ? 1 : 0;
    x.q = m_q; x.tc = tcv; x.wrap = m_wrap; x.err = m_err;
    x.j = (~m_q) & nxt & ((1 << W) - 1);
    x.k = m_q & (~nxt) & ((1 << W) - 1);
    exp_q.push_back(x);
    if (r != 0) begin
      m_q = nxt; m_err = e_err; m_wrap = (tcv != 0 && wrapped != 0) ? 1 : 0;
    end
  endtask

  // Monitor: samples 1 time unit after each negedge, once the driver has pushed.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        cmp("q",    int'(q),    x.q);
        cmp("j_o",  int'(j_o),  x.j);
        cmp("k_o",  int'(k_o),  x.k);
        cmp("tc",   int'(tc),   x.tc);
        cmp("wrap", int'(wrap), x.wrap);
        cmp("err",  int'(err),  x.err);
        checks++;
        if ((j_o & k_o) != '0) begin
          errors++;
          $display("FAIL jk_both: j_o=%b k_o=%b", j_o, k_o);
        end
      end
    end
  end

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
    repeat (3) step(0, 1, 1, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0);
    // Down wrap from 0, then walk down through 8->7.
    step(1, 0, 0, 1, 0);
    repeat (4) step(1, 1, 0, 0, 0);
    // Load priority, rejected load, sticky err.
    step(1, 1, 1, 1, 7);
    step(1, 1, 1, 1, 12);
    step(1, 1, 1, 1, 3);
    step(1, 0, 1, 0, 0);
    // Hold at 5.
    step(1, 0, 1, 1, 5);
    repeat (5) step(1, 0, 1, 0, 0);
    // Async reset mid-count at 6: checked before any posedge.
    step(1, 0, 1, 1, 6);
    step(1, 1, 1, 1, 15);
    step(0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0);
    // Saturate-style walk from 7 (wraps by default).
    step(1, 0, 1, 1, 7);
    repeat (5) step(1, 1, 1, 0, 0);
    for (int i = 0; i < 400; i++) begin
      int r, l;
      r = ($urandom_range(0, 49) == 0) ? 0 : 1;
      l = ($urandom_range(0, 5) == 0) ? 1 : 0;
      step(r, int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 1)), l,
           int'($urandom_range(0, (1 << W) - 1)));
    end
    step(1, 0, 1, 0, 0);
    repeat (2) @(negedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
